// File: rtl/seq_ser_feeder_pkg.sv
// seq_pkg: shared state encoding, default width and counter-width helper for seq_ser_feeder
package seq_pkg;
   typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;
   localparam int DEF_WIDTH = 8;
   function automatic int cnt_width(input int w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction
   localparam int DEF_CNT_W = cnt_width(DEF_WIDTH);
endpackage

// File: rtl/seq_ser_feeder_if.sv
// seq_ser_feeder_if: word handshake in, serial bit stream and status out
//   in_data/in_valid : source -> feeder parallel word offer
//   in_ready         : feeder -> source, word can be taken this cycle
//   data_out/out_valid/word_done/busy : feeder serial output and status
interface seq_ser_feeder_if
   import seq_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic             data_out;
   logic             out_valid;
   logic             word_done;
   logic             busy;
   modport master (output in_data, in_valid, input in_ready, data_out, out_valid, word_done, busy);
   modport slave  (input in_data, in_valid, output in_ready, data_out, out_valid, word_done, busy);
endinterface

// File: rtl/seq_ser_feeder_hold_reg.sv
// seq_hold_reg: single-entry hold register with valid/ready handshake
//   clk, rst         : clock, async active-high reset
//   in_data/in_valid : offered word; in_ready registered as !full of next cycle
//   take             : consumer empties the entry this edge
//   data/full        : held word and occupancy; full_nxt is next-cycle occupancy
module seq_hold_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             take,
   output logic [WIDTH-1:0] data,
   output logic             full,
   output logic             full_nxt
);
   logic [WIDTH-1:0] data_q, data_d;
   logic             full_q, full_d, ready_q, ready_d, accept;
   // accept needs an empty entry and take needs a full one, so they never coincide
   always_comb begin
      accept = in_valid && ready_q;
      data_d = accept ? in_data : data_q;
      full_d = take ? 1'b0 : (accept ? 1'b1 : full_q);
      ready_d = !full_d;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q  <= '0;
         full_q  <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         full_q  <= full_d;
         ready_q <= ready_d;
      end
   end
   assign in_ready = ready_q;
   assign data     = data_q;
   assign full     = full_q;
   assign full_nxt = full_d;
endmodule

// File: rtl/seq_ser_feeder.sv
// seq_ser_feeder: parallel-to-serial feeder for the sequence detector
//   Clock, reset : clock, async active-high reset
//   bus (slave)  : in_data/in_valid/in_ready word handshake; registered data_out,
//                  out_valid, word_done (last bit of word) and busy status
module seq_ser_feeder
   import seq_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter bit MSB_FIRST = 1'b1,
   parameter bit IDLE_BIT  = 1'b0
) (
   input logic              Clock,
   input logic              reset,
   seq_ser_feeder_if.slave  bus
);
   localparam int             CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);
   state_t           state_q, state_d;
   logic [WIDTH-1:0] sr_q, sr_d, hold_data;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             hold_full, hold_full_nxt, hold_ready, take, last, shifting;
   logic             data_out_q, data_out_d, out_valid_q, out_valid_d;
   logic             word_done_q, word_done_d, busy_q, busy_d;
   seq_hold_reg #(.WIDTH(WIDTH)) u_hold (
      .clk      (Clock),
      .rst      (reset),
      .in_data  (bus.in_data),
      .in_valid (bus.in_valid),
      .in_ready (hold_ready),
      .take     (take),
      .data     (hold_data),
      .full     (hold_full),
      .full_nxt (hold_full_nxt)
   );
   // outputs are computed from next-state values so the registered bit matches cnt
   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      last    = (state_q == ST_SHIFT) && (cnt_q == LAST);
      take    = hold_full && ((state_q == ST_IDLE) || last);
      if (take) begin
         state_d = ST_SHIFT;
         sr_d    = hold_data;
         cnt_d   = '0;
      end else if (last) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else if (state_q == ST_SHIFT) begin
         sr_d  = MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);
         cnt_d = cnt_q + CW'(1);
      end
      shifting    = (state_d == ST_SHIFT);
      data_out_d  = shifting ? (MSB_FIRST ? sr_d[WIDTH-1] : sr_d[0]) : IDLE_BIT;
      out_valid_d = shifting;
      word_done_d = shifting && (cnt_d == LAST);
      busy_d      = shifting || hold_full_nxt;
   end
   always_ff @(posedge Clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         sr_q        <= '0;
         cnt_q       <= '0;
         data_out_q  <= IDLE_BIT;
         out_valid_q <= 1'b0;
         word_done_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         cnt_q       <= cnt_d;
         data_out_q  <= data_out_d;
         out_valid_q <= out_valid_d;
         word_done_q <= word_done_d;
         busy_q      <= busy_d;
      end
   end
   assign bus.in_ready  = hold_ready;
   assign bus.data_out  = data_out_q;
   assign bus.out_valid = out_valid_q;
   assign bus.word_done = word_done_q;
   assign bus.busy      = busy_q;
endmodule

// File: tb/tb_seq_ser_feeder.sv
// tb_seq_ser_feeder: directed self-checking bench for seq_ser_feeder (MSB-first and LSB-first)
module tb_seq_ser_feeder;
   logic Clock = 1'b0;
   logic reset = 1'b1;
   int   pass = 0;
   int   total = 0;
   seq_ser_feeder_if #(.WIDTH(8)) bus ();
   seq_ser_feeder_if #(.WIDTH(8)) bus_l ();
   seq_ser_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
      .Clock (Clock),
      .reset (reset),
      .bus   (bus)
   );
   seq_ser_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
      .Clock (Clock),
      .reset (reset),
      .bus   (bus_l)
   );
   always #5 Clock = ~Clock;

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic test_reset();
      #2;
      total++; if (bus.data_out !== 1'b0) $display("FAIL rst_dout: got %b want 0", bus.data_out); else pass++;
      total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_ovalid: got %b want 0", bus.out_valid); else pass++;
      total++; if (bus.in_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", bus.in_ready); else pass++;
      total++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.busy); else pass++;
      total++; if (bus.word_done !== 1'b0) $display("FAIL rst_wdone: got %b want 0", bus.word_done); else pass++;
      #19;
      reset = 1'b0;
      total++; if (bus.in_ready !== 1'b0) $display("FAIL rel_ready_pre_edge: got %b want 0", bus.in_ready); else pass++;
      step();
      total++; if (bus.in_ready !== 1'b1) $display("FAIL rel_ready_first_edge: got %b want 1", bus.in_ready); else pass++;
      total++; if (bus_l.in_ready !== 1'b1) $display("FAIL rel_ready_lsb: got %b want 1", bus_l.in_ready); else pass++;
      for (int c = 0; c < 3; c++) begin
         total++; if (bus.out_valid !== 1'b0 || bus.data_out !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL idle_c%0d: got ov=%b do=%b busy=%b want 0 0 0", c, bus.out_valid, bus.data_out, bus.busy); else pass++;
         step();
      end
   endtask

   task automatic test_single();
      logic [7:0] w;
      w = 8'hDB;
      bus.in_data = w;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      total++; if (bus.out_valid !== 1'b0) $display("FAIL single_lat_ovalid: got %b want 0", bus.out_valid); else pass++;
      total++; if (bus.busy !== 1'b1) $display("FAIL single_busy_hold: got %b want 1", bus.busy); else pass++;
      total++; if (bus.in_ready !== 1'b0) $display("FAIL single_ready_full: got %b want 0", bus.in_ready); else pass++;
      step();
      for (int s = 0; s < 8; s++) begin
         total++; if (bus.out_valid !== 1'b1) $display("FAIL single_ovalid_b%0d: got %b want 1", s, bus.out_valid); else pass++;
         total++; if (bus.data_out !== w[7-s]) $display("FAIL single_bit_b%0d: got %b want %b", s, bus.data_out, w[7-s]); else pass++;
         total++; if (bus.word_done !== (s == 7)) $display("FAIL single_wdone_b%0d: got %b want %b", s, bus.word_done, (s == 7)); else pass++;
         step();
      end
      total++; if (bus.out_valid !== 1'b0 || bus.data_out !== 1'b0 || bus.word_done !== 1'b0 || bus.busy !== 1'b0)
         $display("FAIL single_end: got ov=%b do=%b wd=%b busy=%b want 0 0 0 0", bus.out_valid, bus.data_out, bus.word_done, bus.busy); else pass++;
   endtask

   task automatic test_back_to_back();
      logic [15:0] st;
      st = 16'hDB6E;
      bus.in_data = 8'hDB;
      bus.in_valid = 1'b1;
      step();
      bus.in_data = 8'h6E;
      total++; if (bus.in_ready !== 1'b0) $display("FAIL b2b_ready_full: got %b want 0", bus.in_ready); else pass++;
      step();
      for (int s = 0; s < 16; s++) begin
         if (s == 0) begin
            total++; if (bus.in_ready !== 1'b1) $display("FAIL b2b_ready_after_xfer: got %b want 1", bus.in_ready); else pass++;
         end
         total++; if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1)
            $display("FAIL b2b_ovalid_b%0d: got ov=%b busy=%b want 1 1", s, bus.out_valid, bus.busy); else pass++;
         total++; if (bus.data_out !== st[15-s]) $display("FAIL b2b_bit_b%0d: got %b want %b", s, bus.data_out, st[15-s]); else pass++;
         total++; if (bus.word_done !== (s == 7 || s == 15))
            $display("FAIL b2b_wdone_b%0d: got %b want %b", s, bus.word_done, (s == 7 || s == 15)); else pass++;
         step();
         if (s == 0) bus.in_valid = 1'b0;
      end
      total++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0)
         $display("FAIL b2b_end: got ov=%b busy=%b want 0 0", bus.out_valid, bus.busy); else pass++;
   endtask

   task automatic test_backpressure();
      logic [7:0]  arr [11];
      logic [23:0] st;
      arr = '{8'hA5, 8'h11, 8'h3C, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'hC3};
      st = 24'hA53CC3;
      for (int c = 0; c <= 26; c++) begin
         if (c == 0 || c == 2 || c == 10 || c == 18) begin
            total++; if (bus.in_ready !== 1'b1) $display("FAIL bp_ready_c%0d: got %b want 1", c, bus.in_ready); else pass++;
         end
         if (c == 1 || c == 3 || c == 11) begin
            total++; if (bus.in_ready !== 1'b0) $display("FAIL bp_stall_c%0d: got %b want 0", c, bus.in_ready); else pass++;
         end
         if (c >= 2 && c <= 25) begin
            total++; if (bus.out_valid !== 1'b1) $display("FAIL bp_ovalid_c%0d: got %b want 1", c, bus.out_valid); else pass++;
            total++; if (bus.data_out !== st[25-c]) $display("FAIL bp_bit_c%0d: got %b want %b", c, bus.data_out, st[25-c]); else pass++;
            total++; if (bus.word_done !== (c == 9 || c == 17 || c == 25))
               $display("FAIL bp_wdone_c%0d: got %b want %b", c, bus.word_done, (c == 9 || c == 17 || c == 25)); else pass++;
         end else begin
            total++; if (bus.out_valid !== 1'b0) $display("FAIL bp_idle_c%0d: got %b want 0", c, bus.out_valid); else pass++;
         end
         bus.in_valid = (c <= 10);
         bus.in_data = (c <= 10) ? arr[c] : 8'hFF;
         step();
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic test_lsb_first();
      logic [7:0] w;
      w = 8'h03;
      bus_l.in_data = w;
      bus_l.in_valid = 1'b1;
      step();
      bus_l.in_valid = 1'b0;
      total++; if (bus_l.out_valid !== 1'b0) $display("FAIL lsb_lat_ovalid: got %b want 0", bus_l.out_valid); else pass++;
      step();
      for (int s = 0; s < 8; s++) begin
         total++; if (bus_l.out_valid !== 1'b1) $display("FAIL lsb_ovalid_b%0d: got %b want 1", s, bus_l.out_valid); else pass++;
         total++; if (bus_l.data_out !== w[s]) $display("FAIL lsb_bit_b%0d: got %b want %b", s, bus_l.data_out, w[s]); else pass++;
         total++; if (bus_l.word_done !== (s == 7)) $display("FAIL lsb_wdone_b%0d: got %b want %b", s, bus_l.word_done, (s == 7)); else pass++;
         step();
      end
      total++; if (bus_l.out_valid !== 1'b0) $display("FAIL lsb_end: got %b want 0", bus_l.out_valid); else pass++;
   endtask

   task automatic test_reset_mid();
      logic [7:0] w;
      bus.in_data = 8'hFF;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      step();
      bus.in_data = 8'h81;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      step();
      step();
      total++; if (bus.data_out !== 1'b1 || bus.out_valid !== 1'b1 || bus.busy !== 1'b1)
         $display("FAIL mid_pre: got do=%b ov=%b busy=%b want 1 1 1", bus.data_out, bus.out_valid, bus.busy); else pass++;
      #1;
      reset = 1'b1;
      #1;
      total++; if (bus.data_out !== 1'b0 || bus.out_valid !== 1'b0)
         $display("FAIL mid_async: got do=%b ov=%b want 0 0", bus.data_out, bus.out_valid); else pass++;
      total++; if (bus.busy !== 1'b0 || bus.word_done !== 1'b0 || bus.in_ready !== 1'b0)
         $display("FAIL mid_async_status: got busy=%b wd=%b rdy=%b want 0 0 0", bus.busy, bus.word_done, bus.in_ready); else pass++;
      step();
      reset = 1'b0;
      for (int c = 0; c < 10; c++) begin
         step();
         total++; if (bus.out_valid !== 1'b0 || bus.word_done !== 1'b0 || bus.busy !== 1'b0 || bus.data_out !== 1'b0)
            $display("FAIL mid_after_c%0d: got ov=%b wd=%b busy=%b do=%b want 0 0 0 0", c, bus.out_valid, bus.word_done, bus.busy, bus.data_out); else pass++;
      end
      w = 8'h5A;
      bus.in_data = w;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      step();
      for (int s = 0; s < 2; s++) begin
         total++; if (bus.out_valid !== 1'b1 || bus.data_out !== w[7-s])
            $display("FAIL mid_new_b%0d: got ov=%b do=%b want 1 %b", s, bus.out_valid, bus.data_out, w[7-s]); else pass++;
         step();
      end
      repeat (8) step();
   endtask

   initial begin
      bus.in_data = '0;
      bus.in_valid = 1'b0;
      bus_l.in_data = '0;
      bus_l.in_valid = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_lsb_first();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end
endmodule
